// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 multicycle control path:
//   - state_t        : main control FSM states
//   - instr_class_t  : instruction classes produced by legv8_opcode_decode
//   - OP_* constants : 11-bit opcodes and the CBZ / B opcode prefixes
//   - ALUOP_*        : ALUOp encodings, shared with ALUControl
//   - SRCB_*         : ALUSrcB mux encodings
//   - is_mem_state() : states that hold a memory request open
// -----------------------------------------------------------------------------
package legv8_pkg;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC_R,
      ST_WB_R,
      ST_EXEC_ADDR,
      ST_MEM_RD,
      ST_WB_MEM,
      ST_MEM_WR,
      ST_EXEC_BR,
      ST_EXEC_JMP,
      ST_ERROR
   } state_t;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_LOAD,
      CLS_STORE,
      CLS_CBZ,
      CLS_B,
      CLS_ILLEGAL
   } instr_class_t;

   // Full 11-bit opcodes (instr[31:21])
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   // Prefix opcodes: CBZ uses instr[31:24], B uses instr[31:26]
   localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
   localparam logic [5:0]  OP_B_PFX   = 6'b000101;

   // ALUOp encodings seen by ALUControl
   localparam logic [1:0]  ALUOP_ADD    = 2'b00;
   localparam logic [1:0]  ALUOP_PASS_B = 2'b01;
   localparam logic [1:0]  ALUOP_RTYPE  = 2'b10;

   // ALUSrcB mux encodings
   localparam logic [1:0]  SRCB_REG     = 2'b00;
   localparam logic [1:0]  SRCB_FOUR    = 2'b01;
   localparam logic [1:0]  SRCB_IMM     = 2'b10;
   localparam logic [1:0]  SRCB_IMM_SH2 = 2'b11;

   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_main_control_if
// Bundle between the main control FSM and the datapath / memory.
//   Into control : opcode[10:0] (instr[31:21]), zero, mem_ready
//   Out of control: ALUOp[1:0], ALUSrcA, ALUSrcB[1:0], Reg2Loc, IorD, mem_req,
//                   MemWrite, IRWrite, MemToReg, RegWrite, PCWrite,
//                   PCWriteCond, PCSource, illegal
// Modports: master = control FSM side, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_main_control_if;

   logic [10:0] opcode;
   logic        zero;
   logic        mem_ready;

   logic [1:0]  ALUOp;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic        Reg2Loc;
   logic        IorD;
   logic        mem_req;
   logic        MemWrite;
   logic        IRWrite;
   logic        MemToReg;
   logic        RegWrite;
   logic        PCWrite;
   logic        PCWriteCond;
   logic        PCSource;
   logic        illegal;

   modport master (
      input  opcode, zero, mem_ready,
      output ALUOp, ALUSrcA, ALUSrcB, Reg2Loc, IorD, mem_req, MemWrite,
             IRWrite, MemToReg, RegWrite, PCWrite, PCWriteCond, PCSource,
             illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  ALUOp, ALUSrcA, ALUSrcB, Reg2Loc, IorD, mem_req, MemWrite,
             IRWrite, MemToReg, RegWrite, PCWrite, PCWriteCond, PCSource,
             illegal
   );

endinterface

// File: rtl/legv8_opcode_decode.sv
// -----------------------------------------------------------------------------
// legv8_opcode_decode
// Combinational classification of the 11-bit LEGv8 opcode.
//   opcode[10:0] in  : instr[31:21]
//   cls          out : instruction class (R / LOAD / STORE / CBZ / B / ILLEGAL)
// Build option LEGV8_B_EN: when defined, 000101xxxxx decodes as B; otherwise
// it falls through to ILLEGAL.
// -----------------------------------------------------------------------------
module legv8_opcode_decode
   import legv8_pkg::*;
(
   input  logic [10:0]  opcode,
   output instr_class_t cls
);

   always_comb begin
      cls = CLS_ILLEGAL;
      if (opcode == OP_ADD || opcode == OP_SUB ||
          opcode == OP_AND || opcode == OP_ORR) begin
         cls = CLS_R;
      end else if (opcode == OP_LDUR) begin
         cls = CLS_LOAD;
      end else if (opcode == OP_STUR) begin
         cls = CLS_STORE;
      end else if (opcode[10:3] == OP_CBZ_PFX) begin
         cls = CLS_CBZ;
      end
`ifdef LEGV8_B_EN
      else if (opcode[10:5] == OP_B_PFX) begin
         cls = CLS_B;
      end
`endif
   end

endmodule

// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
// LEGv8 multicycle main control FSM: FETCH / DECODE / EXEC / MEM / WB.
//   clk  in : system clock, rising edge
//   rst  in : synchronous reset, active-high
//   bus     : multicycle_main_control_if.master
//             in  opcode, zero, mem_ready
//             out ALUOp, ALUSrcA, ALUSrcB, Reg2Loc, IorD, mem_req, MemWrite,
//                 IRWrite, MemToReg, RegWrite, PCWrite, PCWriteCond,
//                 PCSource, illegal
// Parameter MEM_TIMEOUT: cycles a memory request may wait for mem_ready
// before the FSM enters ERROR; 0 disables the timeout.
// Build option LEGV8_B_EN: enables the unconditional branch B (EXEC_JMP).
// Outputs are decoded from registered state only; mem_ready additionally
// qualifies IRWrite/PCWrite in FETCH. While rst is high every output shows
// its reset value (all 0, ALUSrcB=01).
// -----------------------------------------------------------------------------
module multicycle_main_control
   import legv8_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)
(
   input  logic                        clk,
   input  logic                        rst,
   multicycle_main_control_if.master   bus
);

   // Counter only needs to reach MEM_TIMEOUT-1: the cycle after that is the
   // transition into ERROR.
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t            state_reg, state_next;
   logic              is_store_reg, is_store_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   instr_class_t      op_class;
   logic              timeout_hit;

   legv8_opcode_decode u_decode (
      .opcode (bus.opcode),
      .cls    (op_class)
   );

   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_FETCH;
         is_store_reg <= 1'b0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         is_store_reg <= is_store_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_next    = state_reg;
      is_store_next = is_store_reg;

      case (state_reg)
         ST_FETCH: begin
            // A completing access wins over a timeout on the same cycle
            if (bus.mem_ready)     state_next = ST_DECODE;
            else if (timeout_hit)  state_next = ST_ERROR;
         end
         ST_DECODE: begin
            case (op_class)
               CLS_R:     state_next = ST_EXEC_R;
               CLS_LOAD: begin
                  state_next    = ST_EXEC_ADDR;
                  is_store_next = 1'b0;
               end
               CLS_STORE: begin
                  state_next    = ST_EXEC_ADDR;
                  is_store_next = 1'b1;
               end
               CLS_CBZ:   state_next = ST_EXEC_BR;
`ifdef LEGV8_B_EN
               CLS_B:     state_next = ST_EXEC_JMP;
`endif
               default:   state_next = ST_ERROR;
            endcase
         end
         ST_EXEC_R:    state_next = ST_WB_R;
         ST_WB_R:      state_next = ST_FETCH;
         ST_EXEC_ADDR: state_next = is_store_reg ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD: begin
            if (bus.mem_ready)     state_next = ST_WB_MEM;
            else if (timeout_hit)  state_next = ST_ERROR;
         end
         ST_WB_MEM:    state_next = ST_FETCH;
         ST_MEM_WR: begin
            if (bus.mem_ready)     state_next = ST_FETCH;
            else if (timeout_hit)  state_next = ST_ERROR;
         end
         ST_EXEC_BR:   state_next = ST_FETCH;
         ST_EXEC_JMP:  state_next = ST_FETCH;
         ST_ERROR:     state_next = ST_ERROR;
         default:      state_next = ST_ERROR;
      endcase
   end

   // Wait counter: every state change clears it, so entering any memory
   // state starts from zero; it advances only while a request is stalled.
   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (state_next != state_reg) begin
         wait_cnt_next = '0;
      end else if (MEM_TIMEOUT != 0 && is_mem_state(state_reg) &&
                   !bus.mem_ready) begin
         wait_cnt_next = wait_cnt_reg + 1'b1;
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      bus.ALUOp       = ALUOP_ADD;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = SRCB_REG;
      bus.Reg2Loc     = 1'b0;
      bus.IorD        = 1'b0;
      bus.mem_req     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemToReg    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.PCSource    = 1'b0;
      bus.illegal     = 1'b0;

      if (rst) begin
         // Hold the datapath quiet with PC+4 selected until reset releases
         bus.ALUSrcB = SRCB_FOUR;
      end else begin
         case (state_reg)
            ST_FETCH: begin
               bus.mem_req  = 1'b1;
               bus.ALUSrcB  = SRCB_FOUR;
               bus.IRWrite  = bus.mem_ready;
               bus.PCWrite  = bus.mem_ready;
            end
            ST_DECODE: begin
               // Branch target PC + (imm<<2) parked in ALUOut for CBZ
               bus.ALUSrcB  = SRCB_IMM_SH2;
            end
            ST_EXEC_R: begin
               bus.ALUSrcA  = 1'b1;
               bus.ALUOp    = ALUOP_RTYPE;
            end
            ST_WB_R: begin
               bus.RegWrite = 1'b1;
            end
            ST_EXEC_ADDR: begin
               bus.ALUSrcA  = 1'b1;
               bus.ALUSrcB  = SRCB_IMM;
               bus.Reg2Loc  = is_store_reg;
            end
            ST_MEM_RD: begin
               bus.mem_req  = 1'b1;
               bus.IorD     = 1'b1;
            end
            ST_WB_MEM: begin
               bus.RegWrite = 1'b1;
               bus.MemToReg = 1'b1;
            end
            ST_MEM_WR: begin
               bus.mem_req  = 1'b1;
               bus.MemWrite = 1'b1;
               bus.IorD     = 1'b1;
            end
            ST_EXEC_BR: begin
               bus.ALUSrcA     = 1'b1;
               bus.ALUOp       = ALUOP_PASS_B;
               bus.Reg2Loc     = 1'b1;
               bus.PCWriteCond = 1'b1;
               bus.PCSource    = 1'b1;
            end
            ST_EXEC_JMP: begin
               bus.PCWrite  = 1'b1;
               bus.PCSource = 1'b1;
            end
            ST_ERROR: begin
               bus.illegal  = 1'b1;
            end
            default: begin
               bus.illegal  = 1'b1;
            end
         endcase
      end
   end

   // ----------------------------------------------------------- assertions
   a_illegal_to_error: assert property (
      @(posedge clk) disable iff (rst)
      (state_reg == ST_DECODE && op_class == CLS_ILLEGAL) |=> (state_reg == ST_ERROR)
   );

   a_error_is_silent: assert property (
      @(posedge clk) disable iff (rst)
      (state_reg == ST_ERROR) |-> !(bus.RegWrite || bus.PCWrite || bus.PCWriteCond ||
                                    bus.MemWrite || bus.IRWrite || bus.mem_req)
   );

endmodule
